// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state encoding, port ids and data width for the RAM arbiter
package ram_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes plus the RAM-side bus of the arbiter
interface ram_arbiter_if #(parameter int RAM_SIZE = 16);
  import ram_arbiter_pkg::*;
  logic                req0, req1, we0, we1, lock0, lock1, ack0, ack1, ram_we;
  logic [RAM_SIZE-1:0] addr0, addr1, ram_address;
  logic [DATA_W-1:0]   wdata0, wdata1, rdata0, rdata1, ram_wdata, ram_rdata;
  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  ack0, ack1, rdata0, rdata1, ram_address, ram_we, ram_wdata
  );
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output ack0, ack1, rdata0, rdata1, ram_address, ram_we, ram_wdata
  );
endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: two-way round-robin pick, restricted to the lock owner while a lock is held
module ram_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock_valid,
  input  logic lock_owner,
  output logic grant_valid,
  output logic grant_id
);
  always_comb begin
    grant_valid = lock_valid ? (lock_owner ? req1 : req0) : (req0 | req1);
    grant_id    = lock_valid ? lock_owner : ((req0 & req1) ? ~last : req1);
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two requesters onto a single-port synchronous-read RAM
// with round-robin fairness and an optional hold-the-grant lock.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RAM_SIZE = 16
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);
  state_e              state, state_nx;
  logic                last, lock_valid, lock_owner, grant_valid, grant_id;
  logic                owner_req, owner_lock, is_idle;
  logic [RAM_SIZE-1:0] addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;

  ram_arb_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last       (last),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx   = state;
    is_idle    = state == IDLE;
    owner_req  = lock_owner ? bus.req1 : bus.req0;
    owner_lock = lock_owner ? bus.lock1 : bus.lock0;
    state_nx   = is_idle ? (grant_valid ? ACCESS : IDLE) : (state == ACCESS ? RESP : IDLE);
  end

  // last doubles as the response owner: it always names the port being served
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      last       <= PORT1;
      lock_valid <= 1'b0;
      lock_owner <= PORT0;
    end else begin
      we_q <= 1'b0;
      if (is_idle && grant_valid) begin
        addr_q     <= grant_id ? bus.addr1 : bus.addr0;
        wdata_q    <= grant_id ? bus.wdata1 : bus.wdata0;
        we_q       <= grant_id ? bus.we1 : bus.we0;
        last       <= grant_id;
        lock_valid <= grant_id ? bus.lock1 : bus.lock0;
        lock_owner <= grant_id;
      end else if (is_idle && lock_valid && !owner_req && !owner_lock) begin
        lock_valid <= 1'b0;
      end
    end

  assign bus.ram_address = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.ram_we      = we_q;
  assign bus.ack0        = (state == RESP) && (last == PORT0);
  assign bus.ack1        = (state == RESP) && (last == PORT1);
  assign bus.rdata0      = bus.ack0 ? bus.ram_rdata : '0;
  assign bus.rdata1      = bus.ack1 ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table-driven single accesses plus contention, lock and reset sequences,
// checked against per-port expectation queues and a reference memory model.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } vec_t;

  exp_t        q0[$], q1[$];
  bit          order[$];
  logic [15:0] model[logic [15:0]];
  logic [15:0] mem[0:65535];
  vec_t        vec[8];

  ram_arbiter_if #(.RAM_SIZE(16)) bus ();
  ram_arbiter #(.RAM_SIZE(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_address] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_address];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.ack0 || bus.ack1)) begin
      chk("ack_exclusive", {bus.ack0, bus.ack1} == 2'b11, 0);
      if (bus.ack0) begin
        order.push_back(1'b0);
        chk("rdata1_quiet", bus.rdata1, 0);
        chk("ack0_expected", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          if (!e.we) chk("rdata0", bus.rdata0, e.rdata);
        end
      end
      if (bus.ack1) begin
        order.push_back(1'b1);
        chk("rdata0_quiet", bus.rdata0, 0);
        chk("ack1_expected", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          if (!e.we) chk("rdata1", bus.rdata1, e.rdata);
        end
      end
    end
  end

  task automatic raise(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                       input bit lk, input bit push);
    exp_t e;
    if (we && push) model[a] = d;
    e.we    = we;
    e.rdata = model.exists(a) ? model[a] : 16'h0;
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = lk;
      if (push) q1.push_back(e);
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = lk;
      if (push) q0.push_back(e);
    end
  endtask

  task automatic drop(input bit p);
    if (p) begin bus.req1 = 1'b0; bus.lock1 = 1'b0; end
    else   begin bus.req0 = 1'b0; bus.lock0 = 1'b0; end
  endtask

  task automatic wait_ack(input bit p, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = p ? bus.ack1 : bus.ack0;
    end
    chk(p ? "ack1_seen" : "ack0_seen", got, 1);
  endtask

  task automatic access(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                        input bit lk, input int budget);
    raise(p, we, a, d, lk, 1'b1);
    wait_ack(p, budget);
    @(posedge clk);
    #1 drop(p);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    vec[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000};
    vec[1] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF};
    vec[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000};
    vec[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000};
    vec[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h5A5A};
    vec[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000};
    vec[6] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF};
    vec[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000};
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0010] = 16'h1234;
    model[16'h0010] = 16'h1234;
    bus.ram_rdata = 16'h0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0; bus.lock0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0; bus.lock1 = 0;
    #1 rst = 1'b1;
    #12;
    chk("rst_ram_address", bus.ram_address, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_acks", {bus.ack0, bus.ack1}, 0);
    chk("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ram_we", bus.ram_we, 0);
      chk("idle_acks", {bus.ack0, bus.ack1}, 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      raise(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("access_addr", bus.ram_address, vec[i].addr);
      chk("access_we", bus.ram_we, vec[i].we);
      if (vec[i].we) chk("access_wdata", bus.ram_wdata, vec[i].wdata);
      chk("access_no_ack", {bus.ack0, bus.ack1}, 0);
      @(negedge clk);
      chk("resp_ack", {bus.ack1, bus.ack0}, vec[i].port ? 2'b10 : 2'b01);
      chk("resp_we_low", bus.ram_we, 0);
      @(posedge clk);
      #1 drop(vec[i].port);
    end
    raise(1'b1, 1'b1, 16'h0030, 16'hAAAA, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("midop_we_before", bus.ram_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("midop_we_dropped", bus.ram_we, 0);
    chk("midop_no_ack", bus.ack1, 0);
    chk("midop_addr_cleared", bus.ram_address, 0);
    drop(1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 access(1'b0, 1'b0, 16'h0030, 16'h0, 1'b0, 4);
    pulse_reset();
    order.delete();
    fork
      for (int i = 0; i < 4; i++) access(1'b0, 1'b1, 16'h0100 + 16'(i), 16'hC000 + 16'(i), 1'b0, 10);
      for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 10);
    join
    chk("rr_count", order.size(), 8);
    for (int i = 0; i < 8; i++) chk("rr_order", i < order.size() ? order[i] : 1'bx, i % 2);
    order.delete();
    fork
      begin
        access(1'b1, 1'b1, 16'h0200, 16'h1111, 1'b1, 10);
        access(1'b1, 1'b1, 16'h0201, 16'h2222, 1'b1, 10);
        access(1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 10);
      end
      begin
        @(posedge clk);
        #2 raise(1'b0, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b1);
        wait_ack(1'b0, 30);
        @(posedge clk);
        #1 drop(1'b0);
      end
    join
    chk("lock_count", order.size(), 4);
    for (int i = 0; i < 4; i++) chk("lock_order", i < order.size() ? order[i] : 1'bx, i < 3);
    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port, synchronous-read data RAM between two requesters: port 0 (CPU control unit, LDR/STR/PUSH/POP) and port 1 (program loader / debug port). A three-state FSM serialises accesses with round-robin fairness. An optional lock lets one requester hold the RAM across consecutive accesses, for example a read-modify-write or stack sequence. The block sits between the requesters and the RAM, which has a 16-bit data width and a 1-cycle read latency.

## Interface
- RAM_SIZE, 16, address width in bits; the RAM holds 2**RAM_SIZE words.
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request. Held high with a stable payload until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  RAM_SIZE  word address.
- wdata0 / wdata1  in  16  write data.
- lock0 / lock1  in  1  request to keep the grant after this access completes.
- ack0 / ack1  out  1  single-cycle completion pulse.
- rdata0 / rdata1  out  16  read data, valid only while the matching ack is high.
- ram_address  out  RAM_SIZE  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  16  registered RAM write data.
- ram_rdata  in  16  RAM read data, valid one cycle after the address is presented.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: RAM address and control are driven.
  - RESP: read data returns; ack pulses.
- IDLE, choosing a winner:
  - Only req0 high → port 0. Only req1 high → port 1.
  - Both high → the port that was not granted last (round-robin pointer `last`).
  - Lock override: if a lock is held, only the lock owner is considered, and the other request waits.
- IDLE, on choosing a winner W:
  - Register addr/we/wdata of W into ram_address/ram_we/ram_wdata.
  - Set `last` = W.
  - If lockW = 1, set lock owner = W. If lockW = 0, clear the lock.
  - Go to ACCESS.
- ACCESS:
  - ram_we is high for exactly this cycle, and only for writes.
  - Go to RESP.
- RESP:
  - ackW = 1.
  - rdataW = ram_rdata. On writes rdata is don't-care; the bench ignores it.
  - ram_we = 0.
  - Go to IDLE.
- Non-granted port: its ack is 0 and its rdata is 0.
- Lock release without a grant: in IDLE, if the lock owner has req = 0 and lock = 0, the lock clears that cycle.
- No request in IDLE: stay in IDLE. ram_address holds its value; ram_we = 0.
- Address is used as given; no wrap or range checks, because the width matches the RAM.

## Timing
- Reset (async) forces:
  - state = IDLE, `last` = 1 (so port 0 wins the first tie), lock cleared.
  - ram_address = 0, ram_we = 0, ram_wdata = 0.
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0.
- Reset mid-access abandons the transfer: no ack is issued, and ram_we drops immediately.
- Latency: request sampled in IDLE at edge k → ACCESS during cycle k+1 → ack during cycle k+2. Three cycles per access.
- Requesters drop or change req at the first edge after ack. The arbiter next samples req in IDLE one cycle later, so a stale req is never re-granted.
- Sustained throughput: one access per 3 cycles. Under contention without locks, the ports alternate.
- Simultaneous req0/req1 rising together after reset: port 0 is served first, then port 1.

## Structure
- Package ram_arbiter_pkg:
  - State encoding: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10.
  - Port IDs: PORT0 = 1'b0, PORT1 = 1'b1.
  - Data width constant: 16.
- Sub-module ram_arb_pick: combinational two-way round-robin pick.
  - Inputs: req0, req1, last, lock_valid, lock_owner.
  - Outputs: grant_valid, grant_id.
- Top level holds the FSM, payload registers, lock state and response muxing.

## Test plan
- Single read: RAM[0x0010] = 0x1234; req0 = 1, we0 = 0, addr0 = 0x0010 → ram_address = 0x0010 during ACCESS, then ack0 = 1 with rdata0 = 0x1234 two cycles after sampling. ack1 stays 0.
- Single write: req1 = 1, we1 = 1, addr1 = 0x0020, wdata1 = 0xBEEF → ram_we high for one cycle with ram_wdata = 0xBEEF, then ack1. A following port 0 read of 0x0020 returns 0xBEEF.
- Contention: req0 and req1 both held for four accesses each → grant order 0, 1, 0, 1, …. Neither port waits more than one access.
- Lock: port 1 issues 3 accesses with lock1 = 1, 1, 0 while req0 is held throughout → all three port 1 accesses complete before ack0.
- Reset mid-op: assert rst during ACCESS of a write → ram_we = 0 immediately, no ack. After release, a req0 read is granted first and completes normally.
- Idle: no requests for 10 cycles → ram_we = 0, ack0 = ack1 = 0, state remains IDLE.
